// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute stage with ALU decode/compute, iterative signed multiplier and branch adder
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       function_code,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             mul_start,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] offset,
    output logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Zero,
    output logic             overflow,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [WIDTH-1:0] branch_target
);
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1000;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_INV = 4'b1111;
    localparam int CW = $clog2(MUL_ITER);

    logic [3:0]         funct_ctrl;
    logic [WIDTH-1:0]   sum, diff;
    logic               add_ovf, sub_ovf, slt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               last, mul_accept, mul_ovf;

    always_comb begin
        funct_ctrl = C_INV;
        case (function_code)
            6'b100000: funct_ctrl = C_ADD;
            6'b100010: funct_ctrl = C_SUB;
            6'b100100: funct_ctrl = C_AND;
            6'b100101: funct_ctrl = C_OR;
            6'b100111: funct_ctrl = C_NOR;
            6'b101010: funct_ctrl = C_SLT;
            6'b011000: funct_ctrl = C_MUL;
            default:   funct_ctrl = C_INV;
        endcase
    end

    assign ALUControl = ALUOp == 2'b00 ? C_ADD :
                        ALUOp == 2'b01 ? C_SUB :
                        ALUOp == 2'b11 ? C_OR  : funct_ctrl;

    assign sum     = read_data1 + data2;
    assign diff    = read_data1 - data2;
    assign add_ovf = (read_data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != read_data1[WIDTH-1]);
    assign sub_ovf = (read_data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != read_data1[WIDTH-1]);
    assign slt     = $signed(read_data1) < $signed(data2);

    // A start pulse is only honoured for a MUL instruction on an idle multiplier
    assign mul_accept = mul_start && ALUControl == C_MUL && !mul_busy;
    assign last       = cnt == CW'(MUL_ITER - 1);
    assign mul_ovf    = mul_done && (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});

    // Signed shift-add: the final (sign) bit of the multiplier carries negative weight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_busy <= 1'b0;
            mul_done <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else if (mul_accept) begin
            mcand    <= {{WIDTH{read_data1[WIDTH-1]}}, read_data1};
            mplier   <= data2;
            acc      <= '0;
            cnt      <= '0;
            mul_busy <= 1'b1;
            mul_done <= 1'b0;
        end else if (mul_busy) begin
            if (mplier[0])
                acc <= last ? acc - mcand : acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                mul_busy <= 1'b0;
                mul_done <= 1'b1;
            end
        end
    end

    always_comb begin
        ALU_out  = '0;
        overflow = 1'b0;
        case (ALUControl)
            C_ADD: begin
                ALU_out  = sum;
                overflow = add_ovf;
            end
            C_SUB: begin
                ALU_out  = diff;
                overflow = sub_ovf;
            end
            C_AND: ALU_out = read_data1 & data2;
            C_OR:  ALU_out = read_data1 | data2;
            C_NOR: ALU_out = ~(read_data1 | data2);
            C_SLT: ALU_out = WIDTH'(slt);
            C_MUL: begin
                ALU_out  = mul_done ? acc[WIDTH-1:0] : '0;
                overflow = mul_ovf;
            end
            default: begin
                ALU_out  = '0;
                overflow = 1'b0;
            end
        endcase
    end

    assign Zero          = ALU_out == '0;
    assign branch_target = pc_plus4 + (offset << 2);
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table vectors, randomized model checks and multiplier corner sequences
module tb_alu_exec_unit;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010, F_MUL = 6'b011000;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ALUOp;
    logic [5:0]  function_code;
    logic [31:0] read_data1, data2, pc_plus4, offset;
    logic        mul_start;
    logic [3:0]  ALUControl;
    logic [31:0] ALU_out, branch_target;
    logic        Zero, overflow, mul_busy, mul_done;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .function_code(function_code),
        .read_data1(read_data1), .data2(data2), .mul_start(mul_start),
        .pc_plus4(pc_plus4), .offset(offset), .ALUControl(ALUControl),
        .ALU_out(ALU_out), .Zero(Zero), .overflow(overflow), .mul_busy(mul_busy),
        .mul_done(mul_done), .branch_target(branch_target)
    );

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, pc, off;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z, ov;
        logic [31:0] bt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [3:0] ctrl,
                                  output logic [31:0] res, output logic ov);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'b00) ctrl = 4'b0010;
        else if (op == 2'b01) ctrl = 4'b0110;
        else if (op == 2'b11) ctrl = 4'b0001;
        else if (fn == F_ADD) ctrl = 4'b0010;
        else if (fn == F_SUB) ctrl = 4'b0110;
        else if (fn == F_AND) ctrl = 4'b0000;
        else if (fn == F_OR) ctrl = 4'b0001;
        else if (fn == F_NOR) ctrl = 4'b1100;
        else if (fn == F_SLT) ctrl = 4'b0111;
        else if (fn == F_MUL) ctrl = 4'b1000;
        else ctrl = 4'b1111;
        res = 32'h0;
        ov = 1'b0;
        r = 0;
        if (ctrl == 4'b0010) begin
            r = sa + sb;
            res = r[31:0];
            ov = r > MAXI || r < MINI;
        end else if (ctrl == 4'b0110) begin
            r = sa - sb;
            res = r[31:0];
            ov = r > MAXI || r < MINI;
        end else if (ctrl == 4'b0000) res = a & b;
        else if (ctrl == 4'b0001) res = a | b;
        else if (ctrl == 4'b1100) res = ~(a | b);
        else if (ctrl == 4'b0111) res = sa < sb ? 32'd1 : 32'd0;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        logic ov, bad;
        int edges;
        p = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        ov = p != longint'($signed(lo));
        @(negedge clk);
        ALUOp = 2'b10; function_code = F_MUL; read_data1 = a; data2 = b; mul_start = 1'b1;
        @(negedge clk);
        mul_start = 1'b0; read_data1 = $urandom; data2 = $urandom;
        chk("mul_busy_start", 32'(mul_busy), 32'd1);
        chk("mul_done_start", 32'(mul_done), 32'd0);
        edges = 0;
        bad = 1'b0;
        while (!mul_done && edges < 40) begin
            if (ALU_out !== 32'h0 || mul_busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
            edges++;
        end
        chk("mul_latency", 32'(edges), 32'd32);
        chk("mul_out_while_busy", 32'(bad), 32'd0);
        chk("mul_result", ALU_out, lo);
        chk("mul_overflow", 32'(overflow), 32'(ov));
        chk("mul_zero", 32'(Zero), 32'(lo == 32'h0));
        chk("mul_busy_end", 32'(mul_busy), 32'd0);
        repeat (3) @(negedge clk);
        read_data1 = $urandom; data2 = $urandom;
        #1;
        chk("mul_hold", ALU_out, lo);
        chk("mul_done_hold", 32'(mul_done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ec;
        logic [31:0] er;
        logic        eo, bad;
        logic [5:0]  fl[6];
        int          edges;

        tbl[0] = '{2'b10, F_ADD, 32'h7FFFFFFF, 32'h1, 32'h00400004, 32'hFFFFFFFF, 4'b0010, 32'h80000000, 1'b0, 1'b1, 32'h00400000};
        tbl[1] = '{2'b01, 6'h00, 32'h12345678, 32'h12345678, 32'h00400004, 32'h4, 4'b0110, 32'h0, 1'b1, 1'b0, 32'h00400014};
        tbl[2] = '{2'b10, F_SLT, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFC, 32'h1, 4'b0111, 32'h1, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{2'b10, F_NOR, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{2'b10, 6'h3F, 32'h5, 32'h6, 32'h100, 32'h2, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h108};
        tbl[5] = '{2'b00, 6'h15, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0010, 32'h0, 1'b1, 1'b0, 32'h0};
        tbl[6] = '{2'b11, 6'h00, 32'hF0F00000, 32'h00000F0F, 32'h0, 32'h0, 4'b0001, 32'hF0F00F0F, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{2'b10, F_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 4'b0000, 32'h0F000F00, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{2'b10, F_SUB, 32'h80000000, 32'h1, 32'h0, 32'h0, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h0};
        tbl[9] = '{2'b10, F_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b0111, 32'h0, 1'b1, 1'b0, 32'h0};
        fl = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};

        rst = 1'b0; ALUOp = 2'b00; function_code = 6'h0; read_data1 = 32'h0; data2 = 32'h0;
        mul_start = 1'b0; pc_plus4 = 32'h0; offset = 32'h0;
        #12;
        chk("reset_busy", 32'(mul_busy), 32'd0);
        chk("reset_done", 32'(mul_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ALUOp = tbl[i].op; function_code = tbl[i].fn; read_data1 = tbl[i].a; data2 = tbl[i].b;
            pc_plus4 = tbl[i].pc; offset = tbl[i].off;
            #1;
            chk($sformatf("tbl%0d_ctrl", i), 32'(ALUControl), 32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d_out", i), ALU_out, tbl[i].res);
            chk($sformatf("tbl%0d_zero", i), 32'(Zero), 32'(tbl[i].z));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_bt", i), branch_target, tbl[i].bt);
        end

        for (int i = 0; i < 300; i++) begin
            ALUOp = 2'($urandom_range(0, 3));
            function_code = fl[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) function_code = 6'($urandom);
            if (function_code == F_MUL) function_code = 6'h3F;
            read_data1 = $urandom_range(0, 3) == 0 ? {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 3))} : $urandom;
            data2 = $urandom_range(0, 3) == 0 ? read_data1 : $urandom;
            pc_plus4 = $urandom; offset = $urandom;
            model(ALUOp, function_code, read_data1, data2, ec, er, eo);
            #1;
            chk("rand_ctrl", 32'(ALUControl), 32'(ec));
            chk("rand_out", ALU_out, er);
            chk("rand_ovf", 32'(overflow), 32'(eo));
            chk("rand_zero", 32'(Zero), 32'(er == 32'h0));
            chk("rand_bt", branch_target, 32'(pc_plus4 + offset * 32'd4));
        end

        run_mul(32'hFFFFFFFD, 32'h7);
        run_mul(32'h00010000, 32'h00010000);
        run_mul(32'h80000000, 32'hFFFFFFFF);
        run_mul(32'h80000000, 32'h1);
        run_mul(32'h0, 32'h12345678);
        for (int i = 0; i < 5; i++) run_mul($urandom, $urandom);
        for (int i = 0; i < 3; i++) run_mul(32'($signed(-$urandom_range(0, 5000))), 32'($urandom_range(0, 70000)));

        // start pulse while a non-MUL op is decoded is ignored
        @(negedge clk);
        ALUOp = 2'b00; mul_start = 1'b1;
        @(negedge clk);
        mul_start = 1'b0;
        chk("start_non_mul", 32'(mul_busy), 32'd0);
        chk("start_non_mul_done", 32'(mul_done), 32'd1);

        // asynchronous reset in the middle of a multiply
        ALUOp = 2'b10; function_code = F_MUL; read_data1 = 32'd123456; data2 = 32'd789; mul_start = 1'b1;
        @(negedge clk);
        mul_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", 32'(mul_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(mul_busy), 32'd0);
        chk("abort_done", 32'(mul_done), 32'd0);
        chk("abort_out", ALU_out, 32'h0);
        chk("abort_zero", 32'(Zero), 32'd1);
        chk("abort_ctrl", 32'(ALUControl), 32'b1000);
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mul_busy !== 1'b0 || mul_done !== 1'b0 || ALU_out !== 32'h0) bad = 1'b1;
        end
        chk("no_resume", 32'(bad), 32'd0);

        // restart attempt while busy must not disturb the running product
        read_data1 = 32'hFFFFFFFB; data2 = 32'd9; mul_start = 1'b1;
        @(negedge clk);
        mul_start = 1'b0;
        edges = 0;
        repeat (5) begin
            @(negedge clk);
            edges++;
        end
        read_data1 = 32'd2; data2 = 32'd3; mul_start = 1'b1;
        @(negedge clk);
        edges++;
        mul_start = 1'b0;
        while (!mul_done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk("restart_latency", 32'(edges), 32'd32);
        chk("restart_result", ALU_out, 32'hFFFFFFD3);
        chk("restart_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
